// File: rtl/mem_data_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters plus the memory, which is how a testbench or the surrounding top drives it.
interface mem_data_arbiter_if #(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 10
);
  logic [1:0]              i_req_valid;
  logic [1:0]              i_req_wr;
  logic [1:0]              i_req_lock;
  logic [2*p_ADDR_LEN-1:0] i_req_addr;
  logic [2*p_WORD_LEN-1:0] i_req_wr_data;
  logic [1:0]              o_req_ready;
  logic [1:0]              o_rsp_valid;
  logic [p_WORD_LEN-1:0]   o_rsp_data;
  logic [1:0]              o_lock_owner;
  logic                    o_mem_wr_en;
  logic [p_ADDR_LEN-1:0]   o_mem_addr;
  logic [p_WORD_LEN-1:0]   o_mem_wr_data;
  logic [p_WORD_LEN-1:0]   i_mem_rd_data;

  modport slave (
    input  i_req_valid, i_req_wr, i_req_lock, i_req_addr, i_req_wr_data, i_mem_rd_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_lock_owner,
           o_mem_wr_en, o_mem_addr, o_mem_wr_data
  );

  modport master (
    output i_req_valid, i_req_wr, i_req_lock, i_req_addr, i_req_wr_data, i_mem_rd_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_lock_owner,
           o_mem_wr_en, o_mem_addr, o_mem_wr_data
  );
endinterface

// File: rtl/mem_data_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the MEM stage
// (port 0) and the debug/loader port (port 1). A requester may hold a bounded lock
// for uninterrupted multi-word sequences. Read data returns one cycle after the grant
// and is steered to whichever port issued the read.
module mem_data_arbiter #(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 10,
  parameter int p_MAX_LOCK = 8
) (
  input logic i_clk,
  input logic i_rst,
  mem_data_arbiter_if.slave bus
);

  localparam int CntW = $clog2(p_MAX_LOCK + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(p_MAX_LOCK);

  typedef enum logic {
    ARB,
    LOCKED
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [CntW-1:0] lockCnt_q, lockCnt_d;
  logic [1:0]      rspPort_q, rspPort_d;

  logic [1:0] grant;
  logic       granted;
  logic       selPort;

  // Decide the one-hot grant: round-robin on ties in ARB, owner-only while locked.
  always_comb begin
    grant = 2'b00;
    if (state_q == LOCKED) begin
      if (bus.i_req_valid[owner_q]) begin
        grant[owner_q] = 1'b1;
      end
    end else begin
      case (bus.i_req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign granted = |grant;
  // With no grant the memory side shows port 0's fields, so selecting on grant[1] covers both cases.
  assign selPort = grant[1];

  assign bus.o_req_ready   = grant;
  assign bus.o_mem_wr_en   = granted && bus.i_req_wr[selPort];
  assign bus.o_mem_addr    = selPort ? bus.i_req_addr[p_ADDR_LEN +: p_ADDR_LEN]
                                     : bus.i_req_addr[0 +: p_ADDR_LEN];
  assign bus.o_mem_wr_data = selPort ? bus.i_req_wr_data[p_WORD_LEN +: p_WORD_LEN]
                                     : bus.i_req_wr_data[0 +: p_WORD_LEN];
  assign bus.o_rsp_valid   = rspPort_q;
  assign bus.o_rsp_data    = bus.i_mem_rd_data;
  assign bus.o_lock_owner  = (state_q == LOCKED) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  // Next-state logic: lock entry/exit, round-robin history and read-response tracking.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    lockCnt_d = lockCnt_q;
    rspPort_d = 2'b00;

    if (granted) begin
      last_d = selPort;
      if (!bus.i_req_wr[selPort]) begin
        rspPort_d = grant;
      end
    end

    case (state_q)
      ARB: begin
        if (granted && bus.i_req_lock[selPort]) begin
          state_d   = LOCKED;
          owner_d   = selPort;
          lockCnt_d = CntW'(1);
        end
      end
      LOCKED: begin
        // Dropping the lock or hitting the bound ends ownership; the owner then loses the next tie.
        if (!bus.i_req_lock[owner_q] || (lockCnt_q == MaxCnt)) begin
          state_d   = ARB;
          last_d    = owner_q;
          lockCnt_d = '0;
        end else begin
          lockCnt_d = lockCnt_q + CntW'(1);
        end
      end
      default: begin
        state_d   = ARB;
        lockCnt_d = '0;
      end
    endcase
  end

  // State registers; reset abandons any lock and drops a pending read response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ARB;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      lockCnt_q <= '0;
      rspPort_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      lockCnt_q <= lockCnt_d;
      rspPort_q <= rspPort_d;
    end
  end

endmodule
